// File: rtl/reg_file_32x32.sv
// reg_file_32x32: RV32I integer register file, 32 x 32-bit, 2 read / 1 write.
// Optional macro REGFILE_WRITE_BYPASS_EN enables same-edge write-to-read forwarding.
module reg_file_32x32 #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [31:0]       READ_Addr_1,
    input  logic [31:0]       READ_Addr_2,
    input  logic [ADDR_W-1:0] WRITE_Addr,
    input  logic [DATA_W-1:0] WRITE_Data,
    input  logic              WRITE_En,
    input  logic              READ_En,
    output logic [DATA_W-1:0] READ_Data_1,
    output logic [DATA_W-1:0] READ_Data_2,
    output logic              X0_Write_Err
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic              wr_commit;
    logic              wr_x0;
    logic [DATA_W-1:0] rd_val_1;
    logic [DATA_W-1:0] rd_val_2;
    logic              unused_addr_hi;

    // Only the low address bits select a register; the rest are don't-care.
    assign rd_addr_1 = READ_Addr_1[ADDR_W-1:0];
    assign rd_addr_2 = READ_Addr_2[ADDR_W-1:0];
    assign unused_addr_hi = ^{READ_Addr_1[31:ADDR_W], READ_Addr_2[31:ADDR_W]};

    // A write to x0 is dropped and only raises the error flag.
    assign wr_commit = WRITE_En && (WRITE_Addr != '0);
    assign wr_x0     = WRITE_En && (WRITE_Addr == '0);

    // Port-1 read value: x0 hardwired to zero, optional forwarding of the new write.
    always_comb begin
        rd_val_1 = '0;
        if (rd_addr_1 != '0) begin
            rd_val_1 = regs[rd_addr_1];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_commit && (rd_addr_1 == WRITE_Addr)) begin
            rd_val_1 = WRITE_Data;
        end
`endif
    end

    // Port-2 read value: same rules as port 1, evaluated independently.
    always_comb begin
        rd_val_2 = '0;
        if (rd_addr_2 != '0) begin
            rd_val_2 = regs[rd_addr_2];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_commit && (rd_addr_2 == WRITE_Addr)) begin
            rd_val_2 = WRITE_Data;
        end
`endif
    end

    // Register storage: cleared on reset, one write per rising edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[WRITE_Addr] <= WRITE_Data;
        end
    end

    // Registered read outputs; READ_En low holds them for a stall.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            READ_Data_1 <= '0;
            READ_Data_2 <= '0;
        end else if (READ_En) begin
            READ_Data_1 <= rd_val_1;
            READ_Data_2 <= rd_val_2;
        end
    end

    // Sticky x0-write error flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            X0_Write_Err <= 1'b0;
        end else if (wr_x0) begin
            X0_Write_Err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// tb_reg_file_32x32: directed vectors for reg_file_32x32 with a behavioural
// model checked every negative clock edge plus literal spot checks.
module tb_reg_file_32x32;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        err;

    int checks;
    int failures;

    reg_file_32x32 dut (
        .CLK          (clk),
        .RSTN         (rstn),
        .READ_Addr_1  (a1),
        .READ_Addr_2  (a2),
        .WRITE_Addr   (wa),
        .WRITE_Data   (wd),
        .WRITE_En     (we),
        .READ_En      (re),
        .READ_Data_1  (rd1),
        .READ_Data_2  (rd2),
        .X0_Write_Err (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: architectural registers and expected outputs.
    logic [31:0] mem [32];
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        exp_err;

    function automatic logic [31:0] arch_read(input logic [31:0] addr);
        int idx;
        idx = int'(addr % 32);
        if (idx == 0) return 32'h0;
        if (BYPASS && we && wa != 5'd0 && int'(wa) == idx) return wd;
        return mem[idx];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            exp1 = 32'h0;
            exp2 = 32'h0;
            exp_err = 1'b0;
        end else begin
            if (re) begin
                exp1 = arch_read(a1);
                exp2 = arch_read(a2);
            end
            if (we) begin
                if (wa == 5'd0) exp_err = 1'b1;
                else mem[wa] = wd;
            end
        end
    end

    // Continuous comparison against the model.
    always @(negedge clk) begin
        checks++;
        if (rd1 !== exp1 || rd2 !== exp2 || err !== exp_err) begin
            failures++;
            $display("FAIL model t=%0t rd1=%h/%h rd2=%h/%h err=%b/%b",
                     $time, rd1, exp1, rd2, exp2, err, exp_err);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Apply the current inputs on the next rising edge, return just after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        we = 1'b1;
        wa = addr;
        wd = data;
        tick();
        we = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        a1 = '0; a2 = '0; wa = '0; wd = '0; we = 1'b0; re = 1'b0;
        #12;
        check("reset_rd1", rd1, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        rstn = 1'b1;
        re = 1'b1;

        // Write x5 then read it back, then reset asynchronously mid-cycle.
        a1 = 32'd5; a2 = 32'd5;
        wr(5'd5, 32'hDEADBEEF);
        tick();
        check("x5_readback", rd1, 32'hDEADBEEF);
        #1 rstn = 1'b0;
        #1;
        check("async_rst_rd1", rd1, 32'h0);
        check("async_rst_rd2", rd2, 32'h0);
        @(negedge clk);
        #1 rstn = 1'b1;
        tick();
        check("x5_after_rst", rd1, 32'h0);

        // Basic write/read on both ports.
        wr(5'd1, 32'h12345678);
        wr(5'd31, 32'hFFFFFFFF);
        a1 = 32'd1; a2 = 32'd31;
        tick();
        check("basic_p1", rd1, 32'h12345678);
        check("basic_p2", rd2, 32'hFFFFFFFF);

        // x0 write is discarded and raises the sticky flag.
        a1 = 32'd0;
        wr(5'd0, 32'hA5A5A5A5);
        tick();
        check("x0_read", rd1, 32'h0);
        check("x0_err", {31'h0, err}, 32'h1);

        // Same-edge read/write of x7.
        wr(5'd7, 32'h11);
        a1 = 32'd7;
        wr(5'd7, 32'h22);
        check("same_edge", rd1, BYPASS ? 32'h22 : 32'h11);
        tick();
        check("after_same_edge", rd1, 32'h22);

        // Stall holds outputs while writes still commit.
        a1 = 32'd1;
        tick();
        check("pre_stall", rd1, 32'h12345678);
        re = 1'b0;
        a1 = 32'd2;
        wr(5'd1, 32'h55);
        tick();
        check("stall_hold", rd1, 32'h12345678);
        re = 1'b1;
        a1 = 32'd1;
        tick();
        check("post_stall", rd1, 32'h55);

        // Upper address bits ignored.
        wr(5'd3, 32'hCAFE);
        a1 = 32'h0000_0021;
        a2 = 32'hFFFF_FFE3;
        tick();
        check("mask_p1", rd1, 32'h55);
        check("mask_p2", rd2, 32'h0000CAFE);

        // Write to x0 while reading x0: still zero, flag still set.
        a1 = 32'd0;
        wr(5'd0, 32'h1234);
        check("x0_bypass", rd1, 32'h0);
        check("err_sticky", {31'h0, err}, 32'h1);

        // Dual read of the same register.
        a1 = 32'd31; a2 = 32'd31;
        tick();
        check("dual_p1", rd1, 32'hFFFFFFFF);
        check("dual_p2", rd2, 32'hFFFFFFFF);

        // Mixed traffic, checked by the model every cycle.
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            re = ($urandom_range(0, 3) != 0);
            a1 = $urandom;
            a2 = (i % 5 == 0) ? {27'h0, wa} : $urandom;
            tick();
        end
        we = 1'b0;
        re = 1'b1;

        // Reset clears the sticky flag.
        #1 rstn = 1'b0;
        #1;
        check("err_rst", {31'h0, err}, 32'h0);
        @(negedge clk);
        #1 rstn = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
- Integer register file for the single-cycle RV32I core: 32 x 32-bit registers, two read ports, one write port.
- Sits directly downstream of the register-file input mux stage. It consumes that stage's read-address and write-data outputs, plus the rd field and write enable from the control unit.
- Read data feeds the ALU operand muxes and the store-data path.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; x0 included.
- ADDR_W, 5, significant address bits; equals log2(NUM_REGS).

Ports:
- CLK  input  1  core clock; all state updates on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- READ_Addr_1  input  32  port-1 read address from input mux; bits [4:0] used, [31:5] ignored.
- READ_Addr_2  input  32  port-2 read address from input mux; bits [4:0] used, [31:5] ignored.
- WRITE_Addr  input  5  destination register (instruction rd field).
- WRITE_Data  input  32  write data from input mux (PC+4 or writeback result).
- WRITE_En  input  1  commit WRITE_Data to WRITE_Addr at next rising edge.
- READ_En  input  1  1 = update read outputs this cycle; 0 = hold them (stall).
- READ_Data_1  output  32  port-1 read data, registered.
- READ_Data_2  output  32  port-2 read data, registered.
- X0_Write_Err  output  1  sticky flag: a write to x0 was attempted.

Behaviour:
- Reset (RSTN low, asynchronous, any time): all 32 registers = 0; READ_Data_1/2 = 0; X0_Write_Err = 0. Holds while RSTN is low; no writes accepted.
- Reset release: first rising edge with RSTN high behaves as a normal cycle.
- Write: on rising edge with WRITE_En=1 and WRITE_Addr!=0, regs[WRITE_Addr] <= WRITE_Data.
- x0 writes: WRITE_En=1 with WRITE_Addr=0 is discarded, x0 stays 0, X0_Write_Err <= 1. The flag clears only on reset.
- x0 reads: always return 0, independent of storage contents.
- Read latency: 1 cycle. With READ_En=1 at edge N, READ_Data_k <= value of regs[READ_Addr_k[4:0]] as of edge N.
- Simultaneous read/write, same address, same edge:
  - Without the optional feature: READ_Data returns the OLD value (read-before-write).
  - With the optional feature: see Optional Feature.
- Stall: READ_En=0 holds READ_Data_1/2 at their previous values. Writes still commit while stalled.
- Dual read of the same address: both ports return identical data.
- Upper address bits [31:5]: have no effect. Address 0x0000_0021 reads x1.
- State: the register array plus two output registers and one flag; no FSM beyond this.
- Arithmetic: none. Data is passed through at full 32-bit width with no extension.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. When READ_En=1, WRITE_En=1, WRITE_Addr!=0 and READ_Addr_k[4:0]==WRITE_Addr on the same edge, READ_Data_k <= WRITE_Data (new value).
  - Applied per port independently.
  - Reads of x0 still return 0, even if a write to x0 is presented.
- Undefined: read-before-write as stated in Behaviour. No bypass logic is synthesised.

Test Plan:
- Reset: assert RSTN=0 mid-cycle after writing x5=0xDEADBEEF -> READ_Data_1/2 = 0 immediately; after release, reading x5 -> 0x00000000.
- Basic write/read: write x1=0x12345678, x31=0xFFFFFFFF; next cycle read ports 1/2 at addresses 1/31 -> 0x12345678 / 0xFFFFFFFF one cycle later.
- x0 protection: WRITE_En=1, WRITE_Addr=0, WRITE_Data=0xA5A5A5A5, then read x0 -> 0x00000000; X0_Write_Err=1 and stays 1 until reset.
- Same-edge read/write: x7=0x11 held; write x7=0x22 while reading x7 on port 1 -> 0x11 without macro, 0x22 with REGFILE_WRITE_BYPASS_EN; the next read returns 0x22 in both builds.
- Stall: READ_Data_1=0x12345678 from x1; set READ_En=0, write x1=0x55, change READ_Addr_1 to 2 -> output stays 0x12345678; READ_En=1 with address 1 -> 0x55.
- Address masking: READ_Addr_2=0xFFFFFFE3 with x3=0xCAFE -> READ_Data_2=0x0000CAFE.
